// File: rtl/shot_tracker.sv
// rtl/shot_tracker.sv - shot bookkeeping, BCD hit/shot counters, sink status and game over
//
// Purpose: once per score request, latch the shot and the checker result,
// then on the following cycle update the fired map, BCD counters,
// per-class sink flags and the game-over state.
//
// Optional feature macro: SHOT_TRACKER_REPEAT_CHECK_EN
//   defined   - 100-bit fired map, repeat shots flagged and not re-counted
//   undefined - no map, repeat_shot tied low, counters saturate instead
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   score_req            level request; a rising edge starts a shot
//   X, Y                 shot coordinates, valid 1..10
//   something_wrong      input validity flag
//   is_hit, biggest_ship checker result and one-hot ship class at (X,Y)
//   shot_done, rejected  one-cycle pulses after a shot is applied
//   repeat_shot          last accepted shot hit an already-fired square
//   hits_*, shots_*      BCD counters (tens/ones)
//   ships_sunk           sticky per-class sink flags
//   game_over            all TOTAL_SQUARES ship squares hit

module shot_tracker #(
  parameter int TOTAL_SQUARES = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       score_req,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       something_wrong,
  input  logic       is_hit,
  input  logic [4:0] biggest_ship,
  output logic       shot_done,
  output logic       rejected,
  output logic       repeat_shot,
  output logic [3:0] hits_ones,
  output logic [3:0] hits_tens,
  output logic [3:0] shots_ones,
  output logic [3:0] shots_tens,
  output logic [4:0] ships_sunk,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, UPDATE, OVER} state_t;

  state_t     state, state_nxt;

  logic       req_q;
  logic [3:0] x_q, y_q;
  logic       wrong_q, hit_q;
  logic [4:0] bs_q;
  logic [4:0] hit_cnt;
  logic [2:0] cls_cnt [5];

  logic       req, latch, apply, reject, is_new, do_hit;
  logic       cls_any;
  logic [2:0] cls_idx;

`ifdef SHOT_TRACKER_REPEAT_CHECK_EN
  logic [99:0] fired_map;
  logic [6:0]  map_idx;
  logic        repeat_q;
`endif

  function automatic logic [2:0] cls_total(input logic [2:0] k);
    case (k)
      3'd0:    return 3'd4;
      3'd1:    return 3'd3;
      3'd2:    return 3'd3;
      3'd3:    return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    apply     = (state == UPDATE);
    req       = score_req & ~req_q;
    reject    = wrong_q | (x_q < 4'd1) | (x_q > 4'd10) | (y_q < 4'd1) | (y_q > 4'd10);

    // Highest set bit wins when the checker reports several classes.
    cls_any = |bs_q;
    cls_idx = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (bs_q[k]) cls_idx = 3'(k);
    end

`ifdef SHOT_TRACKER_REPEAT_CHECK_EN
    // (Y-1)*10 + (X-1), folded into one constant offset.
    map_idx = 7'(y_q) * 7'd10 + 7'(x_q) - 7'd11;
    is_new  = ~fired_map[map_idx];
    do_hit  = apply & ~reject & is_new & hit_q;
`else
    is_new  = 1'b1;
    do_hit  = apply & ~reject & hit_q & (hit_cnt != 5'(TOTAL_SQUARES));
`endif

    case (state)
      IDLE: begin
        if (req) begin
          latch     = 1'b1;
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        if (do_hit && (hit_cnt + 5'd1 == 5'(TOTAL_SQUARES))) state_nxt = OVER;
        else                                                  state_nxt = IDLE;
      end
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // req_q starts high so a request held through reset does not fire.
      req_q      <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      wrong_q    <= 1'b0;
      hit_q      <= 1'b0;
      bs_q       <= '0;
      shot_done  <= 1'b0;
      rejected   <= 1'b0;
      hit_cnt    <= '0;
      hits_ones  <= '0;
      hits_tens  <= '0;
      shots_ones <= '0;
      shots_tens <= '0;
      ships_sunk <= '0;
      for (int k = 0; k < 5; k++) cls_cnt[k] <= '0;
`ifdef SHOT_TRACKER_REPEAT_CHECK_EN
      fired_map  <= '0;
      repeat_q   <= 1'b0;
`endif
    end else begin
      req_q     <= score_req;
      shot_done <= 1'b0;
      rejected  <= 1'b0;

      if (latch) begin
        x_q     <= X;
        y_q     <= Y;
        wrong_q <= something_wrong;
        hit_q   <= is_hit;
        bs_q    <= biggest_ship;
      end

      if (apply) begin
        shot_done <= 1'b1;
        rejected  <= reject;
        if (!reject) begin
          if (!(shots_tens == 4'd9 && shots_ones == 4'd9))
            {shots_tens, shots_ones} <= bcd_inc(shots_tens, shots_ones);
`ifdef SHOT_TRACKER_REPEAT_CHECK_EN
          repeat_q <= ~is_new;
          if (is_new) fired_map[map_idx] <= 1'b1;
`endif
        end
      end

      if (do_hit) begin
        hit_cnt                <= hit_cnt + 5'd1;
        {hits_tens, hits_ones} <= bcd_inc(hits_tens, hits_ones);
        if (cls_any) begin
`ifdef SHOT_TRACKER_REPEAT_CHECK_EN
          cls_cnt[cls_idx] <= cls_cnt[cls_idx] + 3'd1;
`else
          if (cls_cnt[cls_idx] != cls_total(cls_idx))
            cls_cnt[cls_idx] <= cls_cnt[cls_idx] + 3'd1;
`endif
          if (cls_cnt[cls_idx] + 3'd1 == cls_total(cls_idx))
            ships_sunk[cls_idx] <= 1'b1;
        end
      end
    end
  end

`ifdef SHOT_TRACKER_REPEAT_CHECK_EN
  assign repeat_shot = repeat_q;
`else
  assign repeat_shot = 1'b0;
`endif

  assign game_over = (state == OVER);

endmodule

// File: tb/tb_shot_tracker.sv
// tb/tb_shot_tracker.sv - directed scoreboard bench for shot_tracker

module tb_shot_tracker;

  logic       clock = 1'b0;
  logic       reset;
  logic       score_req;
  logic [3:0] x, y;
  logic       something_wrong, is_hit;
  logic [4:0] biggest_ship;
  logic       shot_done, rejected, repeat_shot, game_over;
  logic [3:0] hits_ones, hits_tens, shots_ones, shots_tens;
  logic [4:0] ships_sunk;

  shot_tracker #(.TOTAL_SQUARES(19)) dut (
    .clock(clock), .reset(reset), .score_req(score_req), .X(x), .Y(y),
    .something_wrong(something_wrong), .is_hit(is_hit), .biggest_ship(biggest_ship),
    .shot_done(shot_done), .rejected(rejected), .repeat_shot(repeat_shot),
    .hits_ones(hits_ones), .hits_tens(hits_tens), .shots_ones(shots_ones),
    .shots_tens(shots_tens), .ships_sunk(ships_sunk), .game_over(game_over)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rej;
    logic       rep;
    logic [3:0] ht, ho, st, so;
    logic [4:0] sunk;
    logic       over;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;

  // Reference model of the game state
  bit         fired [11][11];
  int         m_hits, m_shots;
  int         m_cls [5];
  int         m_tot [5] = '{4, 3, 3, 4, 5};
  logic [4:0] m_sunk;
  bit         m_rep, m_over;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < 11; j++) fired[i][j] = 1'b0;
    m_hits = 0; m_shots = 0; m_sunk = '0; m_rep = 0; m_over = 0;
    for (int k = 0; k < 5; k++) m_cls[k] = 0;
  endtask

  task automatic model_add_hit(input logic [4:0] bs);
    int c;
    c = -1;
    m_hits++;
    for (int k = 0; k < 5; k++) if (bs[k]) c = k;
    if (c >= 0) begin
`ifdef SHOT_TRACKER_REPEAT_CHECK_EN
      m_cls[c]++;
`else
      if (m_cls[c] < m_tot[c]) m_cls[c]++;
`endif
      if (m_cls[c] == m_tot[c]) m_sunk[c] = 1'b1;
    end
  endtask

  task automatic model_shot(input int sx, input int sy, input bit wrong, input bit hit,
                            input logic [4:0] bs, output exp_t e);
    bit rej;
    rej = wrong || sx < 1 || sx > 10 || sy < 1 || sy > 10;
    if (!rej) begin
      if (m_shots < 99) m_shots++;
`ifdef SHOT_TRACKER_REPEAT_CHECK_EN
      if (fired[sx][sy]) m_rep = 1;
      else begin
        fired[sx][sy] = 1;
        m_rep = 0;
        if (hit) model_add_hit(bs);
      end
`else
      m_rep = 0;
      if (hit && m_hits < 19) model_add_hit(bs);
`endif
    end
    if (m_hits == 19) m_over = 1;
    e.rej  = rej;
    e.rep  = m_rep;
    e.ht   = 4'(m_hits / 10);
    e.ho   = 4'(m_hits % 10);
    e.st   = 4'(m_shots / 10);
    e.so   = 4'(m_shots % 10);
    e.sunk = m_sunk;
    e.over = m_over;
  endtask

  task automatic check_outputs(input exp_t e);
    chk("rejected",    8'(rejected),    8'(e.rej));
    chk("repeat_shot", 8'(repeat_shot), 8'(e.rep));
    chk("hits_tens",   8'(hits_tens),   8'(e.ht));
    chk("hits_ones",   8'(hits_ones),   8'(e.ho));
    chk("shots_tens",  8'(shots_tens),  8'(e.st));
    chk("shots_ones",  8'(shots_ones),  8'(e.so));
    chk("ships_sunk",  8'(ships_sunk),  8'(e.sunk));
    chk("game_over",   8'(game_over),   8'(e.over));
  endtask

  // One request; inputs are scrambled after the latch edge to prove they were captured.
  task automatic fire(input int sx, input int sy, input bit wrong, input bit hit, input logic [4:0] bs);
    exp_t e;
    bit   want_pulse;
    int   pulses, lat, waited;
    @(negedge clock);
    x = 4'(sx); y = 4'(sy); something_wrong = wrong; is_hit = hit; biggest_ship = bs;
    want_pulse = !m_over;
    if (want_pulse) begin
      model_shot(sx, sy, wrong, hit, bs, e);
      sb.push_back(e);
    end
    score_req = 1'b1;
    pulses = 0; lat = 0; waited = 0;
    repeat (8) begin
      @(negedge clock);
      score_req = 1'b0;
      x = 4'd3; y = 4'd3; something_wrong = 1'b0; is_hit = ~hit; biggest_ship = 5'b10000;
      waited++;
      if (shot_done) begin
        pulses++;
        if (pulses == 1) begin
          lat = waited;
          if (sb.size() > 0) check_outputs(sb.pop_front());
        end
      end
    end
    chk("pulse_count", 8'(pulses), 8'(want_pulse ? 1 : 0));
    if (want_pulse) chk("latency", 8'(lat), 8'd2);
  endtask

  initial begin
    reset = 1'b1; score_req = 1'b1; x = '0; y = '0;
    something_wrong = 1'b0; is_hit = 1'b0; biggest_ship = '0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("no_pulse_after_reset", 8'(shot_done), 8'd0);
    end
    chk("reset_hits",  8'({hits_tens, hits_ones}),   8'd0);
    chk("reset_shots", 8'({shots_tens, shots_ones}), 8'd0);
    chk("reset_sunk",  8'(ships_sunk), 8'd0);
    chk("reset_over",  8'(game_over),  8'd0);
    chk("reset_rep",   8'(repeat_shot), 8'd0);
    score_req = 1'b0;
    @(negedge clock);

    fire(7, 6, 0, 1, 5'b00001);
    fire(7, 6, 0, 1, 5'b00001);
    fire(3, 3, 1, 1, 5'b00001);
    fire(0, 5, 0, 1, 5'b00001);
    fire(11, 5, 0, 0, 5'b00000);
    fire(5, 0, 0, 0, 5'b00000);
    fire(2, 8, 0, 1, 5'b00010);
    fire(2, 9, 0, 1, 5'b00010);
    fire(2, 10, 0, 1, 5'b00010);
    fire(10, 10, 0, 0, 5'b00000);
    fire(1, 10, 0, 0, 5'b00000);
    // Drive the shot counter into saturation at 99.
    for (int i = 0; i < 92; i++) fire(10, 10, 0, 0, 5'b00000);
    // Multi-bit class: the highest set bit (class 2) must be credited.
    fire(5, 1, 0, 1, 5'b00101);
    fire(5, 2, 0, 1, 5'b00101);
    fire(5, 3, 0, 1, 5'b00100);
    fire(8, 6, 0, 1, 5'b00001);
    fire(9, 6, 0, 1, 5'b00001);
    fire(10, 6, 0, 1, 5'b00001);
    for (int i = 1; i <= 4; i++) fire(1, i, 0, 1, 5'b01000);
    for (int i = 3; i <= 7; i++) fire(i, 5, 0, 1, 5'b10000);
    chk("final_over", 8'(game_over), 8'd1);
    chk("final_hits", 8'({hits_tens, hits_ones}), 8'h19);
    fire(4, 4, 0, 1, 5'b00001);
    chk("still_over", 8'(game_over), 8'd1);

    // Reset arriving during UPDATE aborts the shot and clears everything.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    x = 4'd7; y = 4'd6; is_hit = 1'b1; biggest_ship = 5'b00001; score_req = 1'b1;
    @(negedge clock);
    score_req = 1'b0; reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("abort_no_pulse", 8'(shot_done), 8'd0);
    end
    chk("abort_hits",  8'({hits_tens, hits_ones}),   8'd0);
    chk("abort_shots", 8'({shots_tens, shots_ones}), 8'd0);
    chk("abort_over",  8'(game_over), 8'd0);
    fire(7, 6, 0, 1, 5'b00001);

    chk("scoreboard_empty", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
